// File: rtl/trig_ack_collector_pkg.sv
// Shared types and helpers for the trigger/ACK collector: FSM states, saturating increment, popcount.
package trig_ack_collector_pkg;

    typedef enum logic [2:0] {IDLE, PULSE, WAIT, DONE, HOLD} state_t;

    localparam int MAX_W = 64;

    // Saturates at the all-ones value of a w-bit counter carried in a MAX_W container.
    function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v, input int unsigned w);
        logic [MAX_W-1:0] lim;
        lim = (w >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << w) - MAX_W'(1));
        return (v >= lim) ? lim : v + MAX_W'(1);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/trig_ack_collector_if.sv
// Control/status and pin bundle between the register slave, the collector and the TRG/ACK pins.
interface trig_ack_collector_if #(
    parameter int N_CH   = 12,
    parameter int CNT_W  = 4,
    parameter int STAT_W = 32
);
    logic              TRG_SOFT;
    logic [N_CH-1:0]   TRG_MASK;
    logic [CNT_W-1:0]  MIN_SCRODS_REQUIRED;
    logic              STAT_CLR;
    logic [N_CH-1:0]   ACK;
    logic [N_CH-1:0]   TRG;
    logic              BUSY;
    logic              EVT_DONE;
    logic              EVT_OK;
    logic [N_CH-1:0]   ACK_SEEN;
    logic [CNT_W-1:0]  ACK_COUNT;
    logic [STAT_W-1:0] TRG_STATISTICS;
    logic [STAT_W-1:0] FAIL_COUNT;
    logic [STAT_W-1:0] DROP_COUNT;

    modport master (
        output TRG_SOFT, TRG_MASK, MIN_SCRODS_REQUIRED, STAT_CLR, ACK,
        input  TRG, BUSY, EVT_DONE, EVT_OK, ACK_SEEN, ACK_COUNT,
               TRG_STATISTICS, FAIL_COUNT, DROP_COUNT
    );

    modport slave (
        input  TRG_SOFT, TRG_MASK, MIN_SCRODS_REQUIRED, STAT_CLR, ACK,
        output TRG, BUSY, EVT_DONE, EVT_OK, ACK_SEEN, ACK_COUNT,
               TRG_STATISTICS, FAIL_COUNT, DROP_COUNT
    );
endinterface

// File: rtl/trig_ack_collector_sync.sv
// Per-channel 2-FF synchroniser plus rising-edge detect; edge is usable 2 cycles after the pin rises.
module trig_ack_collector_sync #(
    parameter int N_CH = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] ack_async,
    output logic [N_CH-1:0] ack_rise
);
    logic [N_CH-1:0] s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= ack_async;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign ack_rise = s2 & ~s3;
endmodule

// File: rtl/trig_ack_collector.sv
// Fans a soft trigger out on masked TRG lines, collects ACKs in a bounded window, judges and counts events.
// Accept->TRG 1 cycle; requests arriving while busy are dropped and counted, never queued.
module trig_ack_collector
    import trig_ack_collector_pkg::*;
#(
    parameter int N_CH       = 12,
    parameter int CNT_W      = 4,
    parameter int PULSE_LEN  = 4,
    parameter int ACK_WINDOW = 64,
    parameter int HOLDOFF    = 16,
    parameter int STAT_W     = 32
) (
    input  logic                CLK_80MHZ,
    input  logic                RESET,
    trig_ack_collector_if.slave bus
);
    localparam int PA_MAX  = (PULSE_LEN > ACK_WINDOW) ? PULSE_LEN : ACK_WINDOW;
    localparam int TMR_MAX = (PA_MAX > HOLDOFF) ? PA_MAX : HOLDOFF;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_LEN - 1);
    localparam logic [TMR_W-1:0] WAIT_LD  = TMR_W'(ACK_WINDOW - 1);
    localparam logic [TMR_W-1:0] HOLD_LD  = (HOLDOFF > 0) ? TMR_W'(HOLDOFF - 1) : '0;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [N_CH-1:0]   trg_q, trg_d, seen_q, seen_d, seen_upd, mask_q, ack_rise;
    logic [CNT_W-1:0]  min_q;
    logic              ok_q, ok_d, accept;
    logic [STAT_W-1:0] good_q, fail_q, drop_q;

    trig_ack_collector_sync #(.N_CH(N_CH)) u_sync (
        .clk       (CLK_80MHZ),
        .rst       (RESET),
        .ack_async (bus.ACK),
        .ack_rise  (ack_rise)
    );

    // Edges landing on the exit cycle still count toward both the early exit and the verdict.
    assign seen_upd = seen_q | (ack_rise & mask_q);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        trg_d   = trg_q;
        seen_d  = seen_q;
        ok_d    = ok_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.TRG_SOFT) begin
                    accept  = 1'b1;
                    state_d = PULSE;
                    tmr_d   = PULSE_LD;
                    trg_d   = bus.TRG_MASK;
                    seen_d  = '0;
                end
            end
            PULSE: begin
                seen_d = seen_upd;
                if (tmr_q == '0) begin
                    state_d = WAIT;
                    tmr_d   = WAIT_LD;
                    trg_d   = '0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            WAIT: begin
                seen_d = seen_upd;
                if (seen_upd == mask_q || tmr_q == '0) begin
                    state_d = DONE;
                    ok_d    = popcount(MAX_W'(seen_upd)) >= 32'(min_q);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            DONE: begin
                if (HOLDOFF == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                    tmr_d   = HOLD_LD;
                end
            end
            HOLD: begin
                if (tmr_q == '0) state_d = IDLE;
                else             tmr_d   = tmr_q - TMR_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_80MHZ) begin
        if (RESET) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            trg_q   <= '0;
            seen_q  <= '0;
            mask_q  <= '0;
            min_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            trg_q   <= trg_d;
            seen_q  <= seen_d;
            ok_q    <= ok_d;
            if (accept) begin
                mask_q <= bus.TRG_MASK;
                min_q  <= bus.MIN_SCRODS_REQUIRED;
            end
        end
    end

    always_ff @(posedge CLK_80MHZ) begin
        if (RESET || bus.STAT_CLR) begin
            good_q <= '0;
            fail_q <= '0;
            drop_q <= '0;
        end else begin
            if (state_q == DONE) begin
                if (ok_q) good_q <= STAT_W'(sat_inc(MAX_W'(good_q), STAT_W));
                else      fail_q <= STAT_W'(sat_inc(MAX_W'(fail_q), STAT_W));
            end
            if (state_q != IDLE && bus.TRG_SOFT)
                drop_q <= STAT_W'(sat_inc(MAX_W'(drop_q), STAT_W));
        end
    end

    assign bus.TRG            = trg_q;
    assign bus.BUSY           = (state_q != IDLE);
    assign bus.EVT_DONE       = (state_q == DONE);
    assign bus.EVT_OK         = ok_q;
    assign bus.ACK_SEEN       = seen_q;
    assign bus.ACK_COUNT      = CNT_W'(popcount(MAX_W'(seen_q)));
    assign bus.TRG_STATISTICS = good_q;
    assign bus.FAIL_COUNT     = fail_q;
    assign bus.DROP_COUNT     = drop_q;
endmodule
